// File: rtl/gf_poly_mul2.sv
// GF(2^8) polynomial multiplier: p(x)*q(x) with coefficient products reduced
// modulo PRIM_POLY, plus the per-q-coefficient partial products, registered once.
module gf_poly_mul2 #(
  parameter int m                = 255,
  parameter int SIZE             = $clog2(m),
  parameter int n                = 2,
  parameter int flat_size        = (n + 1) * SIZE,
  parameter int large_array      = 2 * n,
  parameter int large_array_size = (large_array + 1) * SIZE,
  parameter int PRIM_POLY        = 'h11D
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [flat_size-1:0]        flat_p,
  input  logic [flat_size-1:0]        flat_q,
  output logic                        out_valid,
  output logic [large_array_size-1:0] flat_z,
  output logic [large_array_size-1:0] out0,
  output logic [large_array_size-1:0] out1,
  output logic [large_array_size-1:0] out2
);

  // The x^SIZE term is implied by the shift, so only the low bits fold back in.
  localparam logic [SIZE-1:0] POLY_LOW = PRIM_POLY[SIZE-1:0];

  // Shift-and-add multiply: a is repeatedly multiplied by x (xtime) and
  // accumulated wherever b has a set bit.
  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] a_sh;
    acc  = '0;
    a_sh = a;
    for (int k = 0; k < SIZE; k++) begin
      if (b[k]) acc = acc ^ a_sh;
      a_sh = {a_sh[SIZE-2:0], 1'b0} ^ (a_sh[SIZE-1] ? POLY_LOW : '0);
    end
    return acc;
  endfunction

  logic [large_array_size-1:0] pp_d [n+1];
  logic [large_array_size-1:0] z_d;

  logic                        out_valid_q;
  logic [large_array_size-1:0] flat_z_q;
  logic [large_array_size-1:0] out0_q;
  logic [large_array_size-1:0] out1_q;
  logic [large_array_size-1:0] out2_q;

  // NOTE: every variable assigned in always_comb gets a full default first,
  // so no path through the loops can leave it holding state (no latches).
  always_comb begin
    z_d = '0;
    for (int i = 0; i <= n; i++) begin
      pp_d[i] = '0;
      for (int j = 0; j <= n; j++) begin
        pp_d[i][(i+j)*SIZE +: SIZE] = gf_mul(flat_p[j*SIZE +: SIZE],
                                             flat_q[i*SIZE +: SIZE]);
      end
      z_d = z_d ^ pp_d[i];
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous and takes priority over loading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      flat_z_q    <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
    end else begin
      out_valid_q <= in_valid;
      flat_z_q    <= z_d;
      out0_q      <= pp_d[0];
      out1_q      <= pp_d[1];
      out2_q      <= pp_d[2];
    end
  end

  assign out_valid = out_valid_q;
  assign flat_z    = flat_z_q;
  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out2      = out2_q;

endmodule

// File: tb/tb_gf_poly_mul2.sv
// Scoreboard bench for gf_poly_mul2: expectations queued at drive time,
// compared one cycle later against an independent long-division GF model.
module tb_gf_poly_mul2;

  typedef struct packed {
    logic        valid;
    logic [39:0] z;
    logic [39:0] o0;
    logic [39:0] o1;
    logic [39:0] o2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] flat_p;
  logic [23:0] flat_q;
  logic        out_valid;
  logic [39:0] flat_z, out0, out1, out2;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  gf_poly_mul2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .flat_p   (flat_p),
    .flat_q   (flat_q),
    .out_valid(out_valid),
    .flat_z   (flat_z),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Full carry-less product, then polynomial long division by 0x11D.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    logic [14:0] poly;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) begin
      poly = 15'h11D << (k - 8);
      if (prod[k]) prod = prod ^ poly;
    end
    return prod[7:0];
  endfunction

  function automatic exp_t model(input logic r, input logic v,
                                 input logic [23:0] p, input logic [23:0] q);
    exp_t e;
    logic [39:0] parts [3];
    logic [7:0]  zk;
    e = '0;
    if (!r) return e;
    e.valid = v;
    for (int i = 0; i < 3; i++) begin
      parts[i] = '0;
      for (int j = 0; j < 3; j++)
        parts[i][(i+j)*8 +: 8] = ref_mul(p[j*8 +: 8], q[i*8 +: 8]);
    end
    for (int k = 0; k < 5; k++) begin
      zk = '0;
      for (int i = 0; i < 3; i++)
        if (k - i >= 0 && k - i <= 2)
          zk = zk ^ ref_mul(p[i*8 +: 8], q[(k-i)*8 +: 8]);
      e.z[k*8 +: 8] = zk;
    end
    e.o0 = parts[0];
    e.o1 = parts[1];
    e.o2 = parts[2];
    return e;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [23:0] p,
                       input logic [23:0] q, input exp_t e);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    flat_p   = p;
    flat_q   = q;
    sb_q.push_back(e);
  endtask

  task automatic drive_model(input logic r, input logic v, input logic [23:0] p,
                             input logic [23:0] q);
    drive(r, v, p, q, model(r, v, p, q));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_valid", 40'(out_valid), 40'(e.valid));
        check("flat_z", flat_z, e.z);
        check("out0", out0, e.o0);
        check("out1", out1, e.o1);
        check("out2", out2, e.o2);
      end
    end
  end

  initial begin : stim
    exp_t e;
    logic [23:0] p, q;
    int budget;
    rst_n = 1'b0; in_valid = 1'b1; flat_p = 24'hABCDEF; flat_q = 24'h123456;

    // Reset held two cycles with live, nonzero inputs.
    drive(1'b0, 1'b1, 24'hABCDEF, 24'h123456, '0);
    drive(1'b0, 1'b1, 24'hFEDCBA, 24'h654321, '0);

    // Basic product, fully hand-derived expectations.
    e.valid = 1'b1;
    e.o0 = 40'h00000C030F; e.o1 = 40'h0; e.o2 = 40'h08020A0000;
    e.z  = 40'h080206030F;
    drive(1'b1, 1'b1, 24'h040105, 24'h020003, e);

    // Reduction cases.
    e = model(1'b1, 1'b1, 24'h000080, 24'h000080); e.z = 40'h0000000013;
    drive(1'b1, 1'b1, 24'h000080, 24'h000080, e);
    e = model(1'b1, 1'b1, 24'h000080, 24'h000002); e.z = 40'h000000001D;
    drive(1'b1, 1'b1, 24'h000080, 24'h000002, e);

    // Identity and zero multiplier.
    p = 24'h9A3C71;
    e = model(1'b1, 1'b1, p, 24'h000001); e.z = {16'h0, p};
    drive(1'b1, 1'b1, p, 24'h000001, e);
    e = '0; e.valid = 1'b1;
    drive(1'b1, 1'b1, 24'hFFFFFF, 24'h000000, e);

    // Back-to-back vectors with out_valid following in_valid.
    drive_model(1'b1, 1'b1, 24'h112233, 24'h445566);
    drive_model(1'b1, 1'b0, 24'h778899, 24'hAABBCC);
    drive_model(1'b1, 1'b1, 24'hDDEEFF, 24'h010203);

    // Reset mid-stream drops the in-flight result; next edge loads normally.
    drive_model(1'b1, 1'b1, 24'hC0FFEE, 24'hBEEF01);
    drive(1'b0, 1'b1, 24'h123456, 24'h789ABC, '0);
    drive_model(1'b1, 1'b1, 24'h0F0E0D, 24'h80FF02);

    for (int i = 0; i < 1000; i++) begin
      p = 24'($urandom);
      q = 24'($urandom);
      drive_model(1'b1, 1'($urandom_range(0, 1)), p, q);
    end

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
